// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT with
// registered decode controls, wait-stated memory handshakes, timeout detection and counters.
module multicycle_control_unit #(
  parameter int CORE            = 0,
  parameter int COUNTER_WIDTH   = 32,
  parameter int MEM_TIMEOUT     = 16,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [6:0]               opcode,
  output logic                     imem_req,
  input  logic                     imem_valid,
  output logic                     ir_write,
  output logic                     dmem_req,
  output logic                     dmem_we,
  input  logic                     dmem_valid,
  output logic                     branch_op,
  output logic                     memRead,
  output logic                     memtoReg,
  output logic                     memWrite,
  output logic                     regWrite,
  output logic                     operand_B_sel,
  output logic [2:0]               ALUOp,
  output logic [1:0]               next_PC_sel,
  output logic [1:0]               operand_A_sel,
  output logic [1:0]               extend_sel,
  output logic                     reg_write_en,
  output logic                     pc_write,
  output logic [2:0]               state,
  output logic                     halted,
  output logic                     illegal,
  output logic                     bus_error,
  output logic [COUNTER_WIDTH-1:0] cycles,
  output logic [COUNTER_WIDTH-1:0] instret,
  input  logic                     report
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef struct packed {
    logic       branch_op;
    logic       mem_read;
    logic       memto_reg;
    logic       mem_write;
    logic       reg_write;
    logic       b_sel;
    logic [2:0] alu_op;
    logic [1:0] next_pc;
    logic [1:0] a_sel;
    logic [1:0] ext;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R:      begin c.alu_op = 3'b000; c.reg_write = 1'b1; end
      OP_I:      begin c.alu_op = 3'b001; c.b_sel = 1'b1; c.reg_write = 1'b1; end
      OP_LOAD:   begin
        c.alu_op = 3'b100; c.b_sel = 1'b1; c.mem_read = 1'b1;
        c.memto_reg = 1'b1; c.reg_write = 1'b1;
      end
      OP_STORE:  begin c.alu_op = 3'b101; c.b_sel = 1'b1; c.ext = 2'b01; c.mem_write = 1'b1; end
      OP_BRANCH: begin c.alu_op = 3'b010; c.branch_op = 1'b1; c.next_pc = 2'b01; end
      OP_JAL:    begin c.alu_op = 3'b011; c.a_sel = 2'b10; c.next_pc = 2'b10; c.reg_write = 1'b1; end
      OP_JALR:   begin c.alu_op = 3'b011; c.a_sel = 2'b10; c.next_pc = 2'b11; c.reg_write = 1'b1; end
      OP_AUIPC:  begin
        c.alu_op = 3'b110; c.a_sel = 2'b01; c.b_sel = 1'b1; c.ext = 2'b10; c.reg_write = 1'b1;
      end
      OP_LUI:    begin
        c.alu_op = 3'b110; c.a_sel = 2'b11; c.b_sel = 1'b1; c.ext = 2'b10; c.reg_write = 1'b1;
      end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_known(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_AUIPC, OP_LUI, OP_FENCE, OP_SYSTEM: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  state_t                   state_q, next_state;
  ctrl_t                    ctrl_q;
  logic                     cur_sys_q, cur_ill_q;
  logic                     illegal_q, bus_error_q;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [COUNTER_WIDTH-1:0] cycles_q, instret_q;
  logic                     wait_expired, timeout;

  assign wait_expired = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      ctrl_q      <= '0;
      cur_sys_q   <= 1'b0;
      cur_ill_q   <= 1'b0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      wait_cnt    <= '0;
      cycles_q    <= '0;
      instret_q   <= '0;
    end else begin
      state_q  <= next_state;
      cycles_q <= cycles_q + COUNTER_WIDTH'(1);
      if (state_q == S_WRITEBACK) instret_q <= instret_q + COUNTER_WIDTH'(1);
      if (state_q == S_DECODE) begin
        ctrl_q    <= decode_ctrl(opcode);
        cur_sys_q <= (opcode == OP_SYSTEM);
        cur_ill_q <= !is_known(opcode);
        if (!is_known(opcode)) illegal_q <= 1'b1;
      end
      if (timeout) bus_error_q <= 1'b1;
      // wait_cnt tracks consecutive unanswered request cycles within one state visit
      if ((state_q == S_FETCH || state_q == S_MEMORY) && next_state == state_q)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state = state_q;
    timeout    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) next_state = S_DECODE;
        else if (wait_expired) begin
          next_state = S_HALT;
          timeout    = 1'b1;
        end
      end
      S_DECODE:  next_state = S_EXECUTE;
      S_EXECUTE: begin
        if (ctrl_q.mem_read || ctrl_q.mem_write) next_state = S_MEMORY;
        else if (cur_sys_q || (cur_ill_q && HALT_ON_ILLEGAL != 0)) next_state = S_HALT;
        else next_state = S_WRITEBACK;
      end
      S_MEMORY: begin
        if (dmem_valid) next_state = S_WRITEBACK;
        else if (wait_expired) begin
          next_state = S_HALT;
          timeout    = 1'b1;
        end
      end
      S_WRITEBACK: next_state = S_FETCH;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_FETCH;
    endcase
  end

  assign state         = state_q;
  assign imem_req      = (state_q == S_FETCH);
  assign ir_write      = (state_q == S_FETCH) && imem_valid;
  assign dmem_req      = (state_q == S_MEMORY);
  assign dmem_we       = (state_q == S_MEMORY) && ctrl_q.mem_write;
  assign reg_write_en  = (state_q == S_WRITEBACK) && ctrl_q.reg_write;
  assign pc_write      = (state_q == S_WRITEBACK);
  assign halted        = (state_q == S_HALT);
  assign illegal       = illegal_q;
  assign bus_error     = bus_error_q;
  assign cycles        = cycles_q;
  assign instret       = instret_q;
  assign branch_op     = ctrl_q.branch_op;
  assign memRead       = ctrl_q.mem_read;
  assign memtoReg      = ctrl_q.memto_reg;
  assign memWrite      = ctrl_q.mem_write;
  assign regWrite      = ctrl_q.reg_write;
  assign operand_B_sel = ctrl_q.b_sel;
  assign ALUOp         = ctrl_q.alu_op;
  assign next_PC_sel   = ctrl_q.next_pc;
  assign operand_A_sel = ctrl_q.a_sel;
  assign extend_sel    = ctrl_q.ext;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report)
      $display("core %0d cycles %0d state %0d branch_op %b memRead %b memtoReg %b memWrite %b regWrite %b operand_B_sel %b ALUOp %b next_PC_sel %b operand_A_sel %b extend_sel %b",
               CORE, cycles_q, state_q, branch_op, memRead, memtoReg, memWrite, regWrite,
               operand_B_sel, ALUOp, next_PC_sel, operand_A_sel, extend_sel);
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a per-cycle scoreboard of stimulus and expected outputs
// drives two instances (timeout 4 / halt on illegal, and no timeout / illegal as NOP).
module tb_multicycle_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       imem_valid = 1'b0;
  logic       dmem_valid = 1'b0;
  logic       report = 1'b0;

  logic d1_imem_req, d1_ir_write, d1_dmem_req, d1_dmem_we, d1_branch_op, d1_memRead, d1_memtoReg;
  logic d1_memWrite, d1_regWrite, d1_operand_B_sel, d1_reg_write_en, d1_pc_write;
  logic d1_halted, d1_illegal, d1_bus_error;
  logic [2:0] d1_ALUOp, d1_state;
  logic [1:0] d1_next_PC_sel, d1_operand_A_sel, d1_extend_sel;
  logic [31:0] d1_cycles, d1_instret;

  logic d2_imem_req, d2_ir_write, d2_dmem_req, d2_dmem_we, d2_branch_op, d2_memRead, d2_memtoReg;
  logic d2_memWrite, d2_regWrite, d2_operand_B_sel, d2_reg_write_en, d2_pc_write;
  logic d2_halted, d2_illegal, d2_bus_error;
  logic [2:0] d2_ALUOp, d2_state;
  logic [1:0] d2_next_PC_sel, d2_operand_A_sel, d2_extend_sel;
  logic [31:0] d2_cycles, d2_instret;

  multicycle_control_unit #(.CORE(0), .COUNTER_WIDTH(32), .MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .imem_req(d1_imem_req), .imem_valid(imem_valid),
    .ir_write(d1_ir_write), .dmem_req(d1_dmem_req), .dmem_we(d1_dmem_we), .dmem_valid(dmem_valid),
    .branch_op(d1_branch_op), .memRead(d1_memRead), .memtoReg(d1_memtoReg), .memWrite(d1_memWrite),
    .regWrite(d1_regWrite), .operand_B_sel(d1_operand_B_sel), .ALUOp(d1_ALUOp),
    .next_PC_sel(d1_next_PC_sel), .operand_A_sel(d1_operand_A_sel), .extend_sel(d1_extend_sel),
    .reg_write_en(d1_reg_write_en), .pc_write(d1_pc_write), .state(d1_state), .halted(d1_halted),
    .illegal(d1_illegal), .bus_error(d1_bus_error), .cycles(d1_cycles), .instret(d1_instret),
    .report(report));

  multicycle_control_unit #(.CORE(1), .COUNTER_WIDTH(32), .MEM_TIMEOUT(0), .HALT_ON_ILLEGAL(0)) dut_nop (
    .clock(clock), .reset(reset), .opcode(opcode), .imem_req(d2_imem_req), .imem_valid(imem_valid),
    .ir_write(d2_ir_write), .dmem_req(d2_dmem_req), .dmem_we(d2_dmem_we), .dmem_valid(dmem_valid),
    .branch_op(d2_branch_op), .memRead(d2_memRead), .memtoReg(d2_memtoReg), .memWrite(d2_memWrite),
    .regWrite(d2_regWrite), .operand_B_sel(d2_operand_B_sel), .ALUOp(d2_ALUOp),
    .next_PC_sel(d2_next_PC_sel), .operand_A_sel(d2_operand_A_sel), .extend_sel(d2_extend_sel),
    .reg_write_en(d2_reg_write_en), .pc_write(d2_pc_write), .state(d2_state), .halted(d2_halted),
    .illegal(d2_illegal), .bus_error(d2_bus_error), .cycles(d2_cycles), .instret(d2_instret),
    .report(1'b0));

  always #5 clock = ~clock;

  logic [9:0]  obs1;
  logic [14:0] ctrl1, ctrl2;
  assign obs1  = {d1_state, d1_imem_req, d1_ir_write, d1_dmem_req, d1_dmem_we,
                  d1_reg_write_en, d1_pc_write, d1_halted};
  assign ctrl1 = {d1_branch_op, d1_memRead, d1_memtoReg, d1_memWrite, d1_regWrite, d1_operand_B_sel,
                  d1_ALUOp, d1_next_PC_sel, d1_operand_A_sel, d1_extend_sel};
  assign ctrl2 = {d2_branch_op, d2_memRead, d2_memtoReg, d2_memWrite, d2_regWrite, d2_operand_B_sel,
                  d2_ALUOp, d2_next_PC_sel, d2_operand_A_sel, d2_extend_sel};

  typedef struct {
    logic [2:0] st;
    logic [6:0] op;
    logic       iv;
    logic       dv;
    logic [9:0] exp;
  } cyc_t;

  cyc_t        sb[$];
  logic [14:0] dq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cycles = 0;
  logic [31:0] exp_instret = 0;

  // {branch_op, memRead, memtoReg, memWrite, regWrite, B_sel, ALUOp, nextPC, A_sel, ext}
  function automatic logic [14:0] ref_ctrl(input logic [6:0] op);
    case (op)
      7'b0110011: return 15'b0_0_0_0_1_0_000_00_00_00;
      7'b0010011: return 15'b0_0_0_0_1_1_001_00_00_00;
      7'b0000011: return 15'b0_1_1_0_1_1_100_00_00_00;
      7'b0100011: return 15'b0_0_0_1_0_1_101_00_00_01;
      7'b1100011: return 15'b1_0_0_0_0_0_010_01_00_00;
      7'b1101111: return 15'b0_0_0_0_1_0_011_10_10_00;
      7'b1100111: return 15'b0_0_0_0_1_0_011_11_10_00;
      7'b0010111: return 15'b0_0_0_0_1_1_110_00_01_10;
      7'b0110111: return 15'b0_0_0_0_1_1_110_00_11_10;
      default:    return 15'd0;
    endcase
  endfunction

  function automatic logic rnd_bit();
    return ($urandom & 1) != 0;
  endfunction

  function automatic cyc_t mk(input logic [2:0] st, input logic [6:0] op, input logic iv,
                              input logic dv, input logic we, input logic rw);
    cyc_t r;
    r.st  = st;
    r.op  = op;
    r.iv  = iv;
    r.dv  = dv;
    r.exp = {st, st == 3'd0, (st == 3'd0) && iv, st == 3'd3, (st == 3'd3) && we,
             (st == 3'd4) && rw, st == 3'd4, st == 3'd5};
    return r;
  endfunction

  task automatic queue_instr(input logic [6:0] op, input int iwait, input int dwait);
    logic [14:0] c;
    logic        mem_op;
    c = ref_ctrl(op);
    mem_op = (op == 7'b0000011) || (op == 7'b0100011);
    for (int i = 0; i < iwait; i++) sb.push_back(mk(3'd0, 7'($urandom), 1'b0, rnd_bit(), 1'b0, 1'b0));
    sb.push_back(mk(3'd0, op, 1'b1, rnd_bit(), 1'b0, 1'b0));
    sb.push_back(mk(3'd1, op, rnd_bit(), rnd_bit(), 1'b0, 1'b0));
    sb.push_back(mk(3'd2, op, rnd_bit(), rnd_bit(), 1'b0, 1'b0));
    if (mem_op) begin
      for (int i = 0; i < dwait; i++) sb.push_back(mk(3'd3, op, rnd_bit(), 1'b0, c[11], 1'b0));
      sb.push_back(mk(3'd3, op, rnd_bit(), 1'b1, c[11], 1'b0));
    end
    if (op == 7'b1110011) sb.push_back(mk(3'd5, op, rnd_bit(), rnd_bit(), 1'b0, 1'b0));
    else sb.push_back(mk(3'd4, op, rnd_bit(), rnd_bit(), 1'b0, c[10]));
    dq.push_back(c);
  endtask

  task automatic run_sb(input string name);
    cyc_t        r;
    logic [14:0] c;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      opcode = r.op; imem_valid = r.iv; dmem_valid = r.dv;
      #1;
      n_checks++;
      if (obs1 !== r.exp) begin
        n_fail++;
        $display("FAIL %s cycle outputs: got %h expected %h", name, obs1, r.exp);
      end
      n_checks++;
      if (d2_state !== r.st) begin
        n_fail++;
        $display("FAIL %s nop-core state: got %0d expected %0d", name, d2_state, r.st);
      end
      if (r.st == 3'd2 && dq.size() > 0) begin
        c = dq.pop_front();
        n_checks++;
        if (ctrl1 !== c) begin
          n_fail++;
          $display("FAIL %s decode: got %b expected %b", name, ctrl1, c);
        end
      end
      @(posedge clock);
      exp_cycles++;
      if (r.st == 3'd4) exp_instret++;
      @(negedge clock);
    end
    n_checks++;
    if ({d1_cycles, d1_instret} !== {exp_cycles, exp_instret}) begin
      n_fail++;
      $display("FAIL %s counters: got cycles %0d instret %0d expected %0d %0d",
               name, d1_cycles, d1_instret, exp_cycles, exp_instret);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; imem_valid = 1'b0; dmem_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_cycles = 0; exp_instret = 0;
    sb.delete(); dq.delete();
  endtask

  task automatic test_reset();
    @(negedge clock);
    #1;
    n_checks++;
    if ({obs1, ctrl1, d1_illegal, d1_bus_error, d1_cycles, d1_instret} !== {10'b000_1_0_0_0_0_0_0, 15'd0, 2'b00, 64'd0}) begin
      n_fail++;
      $display("FAIL reset dut: got %h %h %b%b %0d %0d expected state 0 only imem_req",
               obs1, ctrl1, d1_illegal, d1_bus_error, d1_cycles, d1_instret);
    end
    n_checks++;
    if ({d2_state, d2_imem_req, d2_ir_write, d2_dmem_req, d2_dmem_we, d2_reg_write_en, d2_pc_write,
         d2_halted, d2_illegal, d2_bus_error, ctrl2, d2_cycles, d2_instret}
        !== {3'd0, 1'b1, 8'd0, 15'd0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset nop-core: got state %0d ctrl %h cycles %0d instret %0d expected all zero",
               d2_state, ctrl2, d2_cycles, d2_instret);
    end
  endtask

  task automatic test_add();
    do_reset();
    queue_instr(7'b0110011, 0, 0);
    run_sb("add");
    n_checks++;
    if ({d1_cycles, d1_instret, d1_ALUOp} !== {32'd4, 32'd1, 3'b000}) begin
      n_fail++;
      $display("FAIL add latency: got cycles %0d instret %0d ALUOp %b expected 4 1 000",
               d1_cycles, d1_instret, d1_ALUOp);
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    queue_instr(7'b0000011, 0, 3);
    run_sb("load_wait");
    n_checks++;
    if ({d1_cycles, d1_instret, d1_bus_error, d1_memtoReg} !== {32'd8, 32'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL load_wait totals: got cycles %0d instret %0d bus_error %b memtoReg %b expected 8 1 0 1",
               d1_cycles, d1_instret, d1_bus_error, d1_memtoReg);
    end
  endtask

  task automatic test_store();
    do_reset();
    report = 1'b1;
    queue_instr(7'b0100011, 1, 0);
    run_sb("store");
    report = 1'b0;
    n_checks++;
    if ({d1_extend_sel, d1_ALUOp, d1_regWrite} !== {2'b01, 3'b101, 1'b0}) begin
      n_fail++;
      $display("FAIL store decode: got ext %b ALUOp %b regWrite %b expected 01 101 0",
               d1_extend_sel, d1_ALUOp, d1_regWrite);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [10];
    ops = '{7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111,
            7'b0110111, 7'b0001111, 7'b0000011, 7'b0100011, 7'b0110011};
    do_reset();
    foreach (ops[i]) queue_instr(ops[i], $urandom_range(3, 0), $urandom_range(3, 0));
    queue_instr(7'b1110011, 0, 0);
    sb.push_back(mk(3'd5, 7'b0110011, 1'b1, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(3'd5, 7'b0110011, 1'b1, 1'b1, 1'b0, 1'b0));
    run_sb("back_to_back");
    n_checks++;
    if ({d1_illegal, d1_bus_error, d1_instret} !== {2'b00, 32'd10}) begin
      n_fail++;
      $display("FAIL back_to_back flags: got illegal %b bus_error %b instret %0d expected 0 0 10",
               d1_illegal, d1_bus_error, d1_instret);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    imem_valid = 1'b0; dmem_valid = 1'b1; opcode = 7'b0110011;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if ({d1_state, d1_imem_req, d1_bus_error, d1_halted} !== {3'd0, 3'b100}) begin
        n_fail++;
        $display("FAIL timeout wait %0d: got state %0d req %b err %b halted %b expected 0 1 0 0",
                 i, d1_state, d1_imem_req, d1_bus_error, d1_halted);
      end
      @(posedge clock);
      @(negedge clock);
    end
    #1;
    n_checks++;
    if ({d1_state, d1_imem_req, d1_bus_error, d1_halted} !== {3'd5, 3'b011}) begin
      n_fail++;
      $display("FAIL timeout halt: got state %0d req %b err %b halted %b expected 5 0 1 1",
               d1_state, d1_imem_req, d1_bus_error, d1_halted);
    end
    n_checks++;
    if ({d2_state, d2_imem_req, d2_bus_error} !== {3'd0, 2'b10}) begin
      n_fail++;
      $display("FAIL timeout disabled: got state %0d req %b err %b expected 0 1 0",
               d2_state, d2_imem_req, d2_bus_error);
    end
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if ({d1_cycles, d1_state, d1_imem_req} !== {32'd7, 3'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout counting: got cycles %0d state %0d req %b expected 7 5 0",
               d1_cycles, d1_state, d1_imem_req);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'b1111111; imem_valid = 1'b1; dmem_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    imem_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #1;
    n_checks++;
    if ({d1_state, d2_state, d1_illegal, d2_illegal, ctrl1, ctrl2} !== {3'd2, 3'd2, 2'b11, 30'd0}) begin
      n_fail++;
      $display("FAIL illegal execute: got states %0d %0d illegal %b%b ctrl %h %h expected 2 2 11 0 0",
               d1_state, d2_state, d1_illegal, d2_illegal, ctrl1, ctrl2);
    end
    @(posedge clock);
    @(negedge clock);
    #1;
    n_checks++;
    if ({d1_state, d1_halted, d1_pc_write} !== {3'd5, 2'b10}) begin
      n_fail++;
      $display("FAIL illegal halt: got state %0d halted %b pc_write %b expected 5 1 0",
               d1_state, d1_halted, d1_pc_write);
    end
    n_checks++;
    if ({d2_state, d2_reg_write_en, d2_pc_write, d2_halted} !== {3'd4, 3'b010}) begin
      n_fail++;
      $display("FAIL illegal nop writeback: got state %0d rwe %b pcw %b halted %b expected 4 0 1 0",
               d2_state, d2_reg_write_en, d2_pc_write, d2_halted);
    end
    @(posedge clock);
    @(negedge clock);
    #1;
    n_checks++;
    if ({d2_state, d2_instret, d2_illegal, d1_state, d1_instret, d1_illegal}
        !== {3'd0, 32'd1, 1'b1, 3'd5, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal retire: got nop %0d/%0d/%b halt %0d/%0d/%b expected 0/1/1 5/0/1",
               d2_state, d2_instret, d2_illegal, d1_state, d1_instret, d1_illegal);
    end
  endtask

  task automatic test_reset_mid_memory();
    do_reset();
    sb.push_back(mk(3'd0, 7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(3'd1, 7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(3'd2, 7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(3'd3, 7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(3'd3, 7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0));
    dq.push_back(ref_ctrl(7'b0000011));
    run_sb("mid_reset_lw");
    reset = 1'b1;
    #1;
    n_checks++;
    if ({d1_state, d1_cycles, d1_instret, d1_pc_write, d1_reg_write_en, d1_dmem_req, ctrl1}
        !== {3'd0, 64'd0, 3'b000, 15'd0}) begin
      n_fail++;
      $display("FAIL mid_reset instant: got state %0d cycles %0d instret %0d ctrl %h expected all 0",
               d1_state, d1_cycles, d1_instret, ctrl1);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_cycles = 0; exp_instret = 0;
    queue_instr(7'b0110011, 1, 0);
    run_sb("after_reset_add");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_reset_mid_memory();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised successor to the single-cycle combinational decoder: a Moore/Mealy FSM that sequences each RV32I instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It supports wait-stated instruction and data memories through a req/valid handshake. It registers the datapath decode controls, adds memory timeout detection, illegal-opcode handling, a halt state, and cycle and retired-instruction counters. It sits between the IR, the datapath muxes and the memory interfaces of one core.

Parameters:
CORE, 0, core index used in report output
COUNTER_WIDTH, 32, width of cycles and instret
MEM_TIMEOUT, 16, max wait cycles per memory request; 0 disables the timeout
HALT_ON_ILLEGAL, 1, 1 = illegal opcode halts; 0 = illegal opcode retires as a NOP

Ports:
clock in 1 core clock
reset in 1 asynchronous, active-high; clears all state and outputs
opcode in 7 IR[6:0]; valid from DECODE onward
imem_req out 1 high while in FETCH
imem_valid in 1 instruction ready
ir_write out 1 FETCH & imem_valid; IR latches on this edge
dmem_req out 1 high while in MEMORY
dmem_we out 1 dmem_req & memWrite
dmem_valid in 1 data access complete
branch_op, memRead, memtoReg, memWrite, regWrite, operand_B_sel out 1 each registered decode outputs
ALUOp out 3 registered decode output
next_PC_sel, operand_A_sel, extend_sel out 2 each registered decode outputs
reg_write_en out 1 WRITEBACK & regWrite
pc_write out 1 high in WRITEBACK
state out 3 FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5
halted out 1 state==HALT
illegal out 1 sticky; set on an unrecognised opcode
bus_error out 1 sticky; set on memory timeout
cycles out COUNTER_WIDTH cycles since reset
instret out COUNTER_WIDTH retired instructions
report in 1 print status each clock while high

Behaviour:
- Reset (async): state=FETCH; all decode registers, flags and counters 0.
- Decode table, captured on the edge leaving DECODE and held until the next DECODE:
  - R: ALUOp 000, regWrite.
  - I: ALUOp 001, B_sel, ext 00, regWrite.
  - LOAD: ALUOp 100, B_sel, ext 00, memRead, memtoReg, regWrite.
  - STORE: ALUOp 101, B_sel, ext 01, memWrite.
  - BRANCH: ALUOp 010, branch_op, nextPC 01.
  - JAL: ALUOp 011, A_sel 10, nextPC 10, regWrite.
  - JALR: ALUOp 011, A_sel 10, nextPC 11, regWrite.
  - AUIPC: ALUOp 110, A_sel 01, B_sel, ext 10, regWrite.
  - LUI: ALUOp 110, A_sel 11, B_sel, ext 10, regWrite.
  - FENCE (0001111) and SYSCALL (1110011): all decode outputs 0.
  - Any other opcode: all decode outputs 0, and illegal is set.
- Transitions:
  - FETCH → DECODE on imem_valid.
  - DECODE → EXECUTE unconditionally.
  - EXECUTE → MEMORY for LOAD/STORE.
  - EXECUTE → HALT for SYSCALL, or for illegal when HALT_ON_ILLEGAL=1.
  - EXECUTE → WRITEBACK otherwise (including FENCE, and illegal when HALT_ON_ILLEGAL=0).
  - MEMORY → WRITEBACK on dmem_valid.
  - WRITEBACK → FETCH, with instret+1.
  - HALT is sticky until reset.
- Latency with zero-wait memory (valid in the first req cycle): 4 cycles for non-memory instructions, 5 for LOAD/STORE. Each wait cycle adds 1.
- Timeout: wait_cnt counts consecutive req cycles without valid and clears on state change.
  - If MEM_TIMEOUT>0 and valid is still low in the MEM_TIMEOUT-th req cycle: set bus_error, go to HALT, drop req next cycle.
  - Valid in that same cycle wins; no error is raised.
- Handshake: imem_valid/dmem_valid are ignored outside their own state, and valid without a matching req is ignored.
- Counters:
  - cycles increments every clock after reset, including in HALT.
  - instret increments only in WRITEBACK.
  - Both wrap modulo 2^COUNTER_WIDTH.
- Reset mid-operation: returns to FETCH the same instant. No pc_write or reg_write_en is issued, and counters clear.
- report: each cycle, display CORE, cycles, state and all decode outputs.

Test Plan:
- Reset, then ADD (0110011) with imem/dmem valid on first req → states 0,1,2,4,0; reg_write_en one cycle in state 4; ALUOp=000; instret=1 after 4 cycles.
- LW (0000011), dmem_valid held low 3 cycles → MEMORY lasts 4 cycles, dmem_we=0, memtoReg=1; total 8 cycles; instret=1.
- SW (0100011) → dmem_we=1 in MEMORY, reg_write_en never asserted, ext=01, ALUOp=101.
- MEM_TIMEOUT=4, imem_valid never asserted → bus_error=1 and halted=1 after the 4th FETCH cycle; imem_req low afterwards; cycles keeps counting.
- Opcode 7'b1111111: with HALT_ON_ILLEGAL=1 → illegal=1, HALT after EXECUTE; with HALT_ON_ILLEGAL=0 → illegal=1, retires through WRITEBACK with reg_write_en=0, instret+1.
- Assert reset during MEMORY of a LW → state=0 and counters=0 the same instant; after release, a fresh fetch starts with no spurious pc_write.
